// File: rtl/fetch_controller.sv
// Instruction fetch controller: PC, one-entry instruction register, valid/ready to decode.
// Ports: clk, rst, start, imem_addr/imem_instr, instr/instr_pc/instr_valid/instr_ready,
// branch_valid/branch_target, busy, halted, fetch_count. Optional halt via FETCH_HALT_EN.
module fetch_controller #(
  parameter logic [7:0]  RESET_PC  = 8'h00,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [7:0]  imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] instr,
  output logic [7:0]  instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        branch_valid,
  input  logic [7:0]  branch_target,
  output logic        busy,
  output logic        halted,
  output logic [15:0] fetch_count
);

`ifdef FETCH_HALT_EN
  localparam logic HALT_EN = 1'b1;
`else
  localparam logic HALT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HALT
  } state_t;

  state_t     state;
  logic [7:0] pc;
  logic       xfer;
  logic       load;
  logic       halt_take;

  assign imem_addr = pc;
  assign xfer      = instr_valid && instr_ready;
  // The register refills whenever it is empty or being drained.
  assign load      = !instr_valid || xfer;
  assign halt_take = HALT_EN && xfer && (instr == HALT_WORD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      fetch_count <= '0;
      busy        <= 1'b0;
      halted      <= 1'b0;
    end else begin
      unique case (state)
        IDLE, HALT: begin
          if (start) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            instr_valid <= 1'b0;
            fetch_count <= '0;
            busy        <= 1'b1;
            halted      <= 1'b0;
          end
        end
        FETCH: begin
          if (start) begin
            pc          <= RESET_PC;
            instr_valid <= 1'b0;
            fetch_count <= '0;
          end else if (branch_valid) begin
            // Flush: the held word is dropped even if decode takes it.
            pc          <= branch_target;
            instr_valid <= 1'b0;
          end else begin
            if (xfer && fetch_count != 16'hFFFF)
              fetch_count <= fetch_count + 16'd1;
            if (halt_take) begin
              // PC already points past the halt word.
              state       <= HALT;
              instr_valid <= 1'b0;
              busy        <= 1'b0;
              halted      <= 1'b1;
            end else if (load) begin
              instr       <= imem_instr;
              instr_pc    <= pc;
              instr_valid <= 1'b1;
              pc          <= pc + 8'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: vector table,
// directed halt sequence, and random run against a reference model.
module tb_fetch_controller;

  localparam logic [7:0]  RPC = 8'h00;
  localparam logic [31:0] HW  = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst, start, instr_ready, branch_valid;
  logic [7:0]  branch_target, imem_addr, instr_pc;
  logic [31:0] imem_instr, instr;
  logic        instr_valid, busy, halted;
  logic [15:0] fetch_count;
  logic [31:0] mem [256];
  logic [66:0] obs;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign imem_instr = mem[imem_addr];
  assign obs = {imem_addr, instr, instr_pc, instr_valid,
                fetch_count, busy, halted};

  fetch_controller #(.RESET_PC(RPC), .HALT_WORD(HW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_addr(imem_addr), .imem_instr(imem_instr),
    .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .branch_valid(branch_valid), .branch_target(branch_target),
    .busy(busy), .halted(halted), .fetch_count(fetch_count)
  );

  typedef struct {
    logic        r, s, rdy, bv;
    logic [7:0]  bt, addr;
    logic [31:0] ins;
    logic [7:0]  ipc;
    logic        v;
    logic [15:0] cnt;
    logic        bsy;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic r, logic s, logic rdy, logic bv,
      logic [7:0] bt, logic [7:0] addr, logic [31:0] ins,
      logic [7:0] ipc, logic v, logic [15:0] cnt, logic bsy);
    vec_t e;
    e = '{r, s, rdy, bv, bt, addr, ins, ipc, v, cnt, bsy};
    tbl.push_back(e);
  endfunction

  task automatic check(input string nm, input logic [66:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, obs, exp);
    end
  endtask

  // Reference model: running/halted flags, a pending-word slot, a counter.
  bit          m_run, m_halt, m_v;
  logic [7:0]  m_pc, m_ipc;
  logic [31:0] m_ins;
  logic [15:0] m_cnt;

  task automatic model_edge();
    bit took;
    if (rst) begin
      m_run = 0; m_halt = 0; m_v = 0;
      m_pc = RPC; m_ipc = 0; m_ins = 0; m_cnt = 0;
    end else if (start) begin
      if (m_run || !m_run) begin
        m_run = 1; m_halt = 0; m_v = 0;
        m_pc = RPC; m_cnt = 0;
      end
    end else if (m_run) begin
      if (branch_valid) begin
        m_pc = branch_target;
        m_v = 0;
      end else begin
        took = m_v && instr_ready;
        if (took && m_cnt < 16'hFFFF) m_cnt = m_cnt + 1;
`ifdef FETCH_HALT_EN
        if (took && m_ins == HW) begin
          m_run = 0; m_halt = 1; m_v = 0;
        end
`endif
        if (m_run && (!m_v || took)) begin
          m_ins = mem[m_pc];
          m_ipc = m_pc;
          m_v = 1;
          m_pc = 8'((int'(m_pc) + 1) % 256);
        end
      end
    end
  endtask

  function automatic logic [66:0] mexp();
    return {m_pc, m_ins, m_ipc, m_v, m_cnt, m_run, m_halt};
  endfunction

  task automatic drive(logic r, logic s, logic rdy, logic bv,
                       logic [7:0] bt);
    rst = r; start = s; instr_ready = rdy;
    branch_valid = bv; branch_target = bt;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'(i + 1);
    drive(1, 0, 0, 0, 0);

    add(1,0,0,0,8'h00, 8'h00,32'h0,  8'h00,0,0,0);
    add(0,1,1,0,8'h00, 8'h00,32'h0,  8'h00,0,0,1);
    add(0,0,0,0,8'h00, 8'h01,32'h1,  8'h00,1,0,1);
    add(0,0,1,0,8'h00, 8'h02,32'h2,  8'h01,1,1,1);
    add(0,0,0,0,8'h00, 8'h02,32'h2,  8'h01,1,1,1);
    add(0,0,0,0,8'h00, 8'h02,32'h2,  8'h01,1,1,1);
    add(0,0,0,0,8'h00, 8'h02,32'h2,  8'h01,1,1,1);
    add(0,0,1,0,8'h00, 8'h03,32'h3,  8'h02,1,2,1);
    add(0,0,1,0,8'h00, 8'h04,32'h4,  8'h03,1,3,1);
    add(0,0,1,0,8'h00, 8'h05,32'h5,  8'h04,1,4,1);
    add(0,0,1,1,8'h40, 8'h40,32'h5,  8'h04,0,4,1);
    add(0,0,1,0,8'h00, 8'h41,32'h41, 8'h40,1,4,1);
    add(0,0,1,0,8'h00, 8'h42,32'h42, 8'h41,1,5,1);
    add(0,0,0,1,8'hFE, 8'hFE,32'h42, 8'h41,0,5,1);
    add(0,0,1,0,8'h00, 8'hFF,32'hFF, 8'hFE,1,5,1);
    add(0,0,1,0,8'h00, 8'h00,32'h100,8'hFF,1,6,1);
    add(0,0,1,0,8'h00, 8'h01,32'h1,  8'h00,1,7,1);
    add(0,0,1,0,8'h00, 8'h02,32'h2,  8'h01,1,8,1);
    add(0,1,1,1,8'h80, 8'h00,32'h2,  8'h01,0,0,1);
    add(0,0,1,0,8'h00, 8'h01,32'h1,  8'h00,1,0,1);
    add(1,0,1,0,8'h00, 8'h00,32'h0,  8'h00,0,0,0);
    add(0,0,1,1,8'h10, 8'h00,32'h0,  8'h00,0,0,0);

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].s, tbl[i].rdy, tbl[i].bv, tbl[i].bt);
      @(posedge clk); #1;
      check($sformatf("vec%0d", i),
            {tbl[i].addr, tbl[i].ins, tbl[i].ipc, tbl[i].v,
             tbl[i].cnt, tbl[i].bsy, 1'b0});
    end

`ifdef FETCH_HALT_EN
    mem[2] = HW;
    drive(1, 0, 1, 0, 0);
    @(posedge clk); #1;
    drive(0, 1, 1, 0, 0);
    @(posedge clk); #1;
    drive(0, 0, 1, 0, 0);
    repeat (4) @(posedge clk);
    #1;
    check("halt_stop", {8'h03, HW, 8'h02, 1'b0, 16'd3, 1'b0, 1'b1});
    drive(0, 1, 1, 0, 0);
    @(posedge clk); #1;
    check("halt_restart", {8'h00, HW, 8'h02, 1'b0, 16'd0, 1'b1, 1'b0});
    drive(0, 0, 1, 0, 0);
    @(posedge clk); #1;
    check("halt_refetch", {8'h01, 32'h1, 8'h00, 1'b1, 16'd0, 1'b1, 1'b0});
    mem[2] = 32'h3;
    for (int i = 0; i < 4; i++) mem[$urandom_range(0, 255)] = HW;
`endif

    for (int k = 0; k < 3000; k++) begin
      drive((k == 0) || ($urandom_range(0, 199) == 0),
            $urandom_range(0, 29) == 0,
            $urandom_range(0, 2) != 0,
            $urandom_range(0, 7) == 0,
            8'($urandom));
      model_edge();
      @(posedge clk); #1;
      check($sformatf("rand%0d", k), mexp());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
